vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

- Shares the single synchronous-read frame/program memory port between two requesters:
  - the VGA glyph-address fetch path (read-only, high priority);
  - the CPU load/store port (read/write).
- Sits between the CPU memory interface, the VGA address generator and the block RAM.
- VGA fetches are never dropped; they may be deferred by at most one cycle.
- The CPU is guaranteed forward progress through a starvation counter.

## Interface

Parameters:
- ADDR_W, 16, address width of all ports
- DATA_W, 16, data width of all ports
- MAX_WAIT, 4, consecutive denied CPU cycles before the CPU is forced a grant (range 1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- vga_req  in  1  single-cycle fetch request; at most one per two cycles in normal use
- vga_addr  in  ADDR_W  fetch address, sampled with vga_req
- vga_rdata  out  DATA_W  fetched word; holds until the next vga_valid
- vga_valid  out  1  one-cycle pulse, vga_rdata updated
- vga_overrun  out  1  sticky: a VGA request was lost; cleared only by reset
- cpu_req  in  1  level request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  stable while cpu_req
- cpu_wdata  in  DATA_W  stable while cpu_req
- cpu_rdata  out  DATA_W  read data, valid on cpu_ack of a read; holds afterwards
- cpu_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered write data
- mem_we  out  1  registered write enable
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is sampled

## Operation

- Grant decision each edge, priority highest first:
  1. Forced CPU grant: wait_cnt == MAX_WAIT and cpu_req and not cpu_busy.
  2. Pending VGA request (vga_pend).
  3. New vga_req.
  4. CPU: cpu_req and not cpu_busy.
  5. Idle.
- VGA deferral:
  - A vga_req not granted on its edge is stored in the one-entry vga_pend/pend_addr register.
  - If vga_pend is serviced on the same edge a new vga_req arrives, the new request refills vga_pend.
  - If vga_req arrives while vga_pend is full and vga_pend is not serviced on that edge, the new request is dropped and vga_overrun is set.
- CPU state machine:
  - IDLE -> RD1 on a CPU read grant.
  - RD1 -> RD2 -> IDLE; cpu_ack is pulsed on the RD2 -> IDLE edge.
  - IDLE -> WR on a CPU write grant.
  - WR -> IDLE; cpu_ack is pulsed on that edge.
  - cpu_busy = (state != IDLE). No new CPU grant while busy, so a still-high cpu_req in the ack cycle is not re-issued.
- Starvation counter (wait_cnt, 4 bits):
  - Increments, saturating at MAX_WAIT, on each edge where cpu_req and not cpu_busy and the CPU is denied.
  - Cleared on a CPU grant or when cpu_req is low.
- Memory outputs:
  - On a grant edge, mem_addr, mem_wdata and mem_we are loaded from the winner. mem_we = 1 only for a CPU write.
  - Idle: mem_we = 0; mem_addr and mem_wdata hold.
  - mem_we is high for exactly one cycle per write.
- Read-return tracking: a 2-stage tag pipeline records the owner of each issued read (none / VGA / CPU) and routes mem_rdata to vga_rdata or cpu_rdata.

## Timing

- Reset (async):
  - Outputs: mem_we = 0, mem_addr = 0, mem_wdata = 0, vga_valid = 0, vga_rdata = 0, cpu_ack = 0, cpu_rdata = 0, vga_overrun = 0.
  - Internal: state = IDLE, wait_cnt = 0, vga_pend = 0, tag pipeline cleared.
  - In-flight reads are discarded: no valid or ack is issued after reset deasserts.
- VGA read granted at edge E:
  - mem_addr is driven after E.
  - Memory samples the address at E+1.
  - vga_rdata is captured and vga_valid pulses at E+2.
  - Request-to-valid latency is therefore 2 cycles if granted immediately, 3 if deferred via vga_pend.
- CPU read granted at E: cpu_ack and cpu_rdata at E+2.
- CPU write granted at E: memory write at E+1, cpu_ack at E+1.
- Back-to-back grants are allowed every cycle; the port is fully pipelined.

## Test plan

- **Reset behaviour:** assert reset mid-read (VGA grant at E, reset at E+1) -> no vga_valid ever; all outputs 0; vga_overrun = 0.
- **VGA-only stream:** vga_req every 2 cycles at addrs 0xF000..0xF00F, memory preloaded with addr ^ 0x5A5A -> each vga_valid exactly 2 cycles after its request, with matching data; mem_we never high.
- **CPU write then read:** write 0x1234 to 0x0040, then read 0x0040 with no VGA traffic -> mem_we pulse 1 cycle; write ack 1 cycle after grant; read ack 2 cycles after grant with cpu_rdata = 0x1234.
- **Starvation:** cpu_req held with vga_req every cycle, MAX_WAIT = 4 -> CPU granted on the 5th edge; the VGA request of that edge is serviced from vga_pend next edge; its vga_valid is 3 cycles after the request; vga_overrun stays 0.
- **Overrun:** with vga_pend full and the CPU forced, an extra vga_req on the same edge -> vga_overrun = 1 and stays 1 until reset.
- **Simultaneous requests:** cpu_req and vga_req on the same edge with wait_cnt = 0 -> VGA granted; CPU granted on the next free edge; cpu_req held high during the ack cycle -> no second cpu_ack.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// Bundle of the VGA fetch, CPU load/store and block-RAM signals around the arbiter.
// slave: arbiter view; master: the surrounding requesters and memory.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // VGA glyph-address fetch path
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_valid;
  logic              vga_overrun;
  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  // Block RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    output vga_rdata, vga_valid, vga_overrun,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_rdata, vga_valid, vga_overrun,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Shares one synchronous-read memory port between the VGA fetch path
// (high priority, deferrable by one cycle) and the CPU load/store port
// (starvation-protected by a saturating wait counter).
module vga_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  vga_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD1, ST_RD2, ST_WR} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state_q;
  tag_t              tag0_q, tag1_q;
  logic [3:0]        wait_q, wait_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] vga_rdata_q, cpu_rdata_q;
  logic              vga_valid_q, cpu_ack_q;

  logic cpu_can, grant_force, grant_pend, grant_new, grant_cpu, cpu_grant, vga_grant;

  // Grant decision for this edge, highest priority first.
  always_comb begin
    cpu_can     = bus.cpu_req && (state_q == ST_IDLE);
    grant_force = cpu_can && (wait_q == MAX_WAIT_C);
    grant_pend  = !grant_force && pend_q;
    grant_new   = !grant_force && !pend_q && bus.vga_req;
    grant_cpu   = !grant_force && !pend_q && !bus.vga_req && cpu_can;
    cpu_grant   = grant_force || grant_cpu;
    vga_grant   = grant_pend || grant_new;
  end

  // Next values for the VGA deferral slot, overrun flag and starvation counter.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    if (grant_pend) begin
      // A request arriving while the slot drains takes its place.
      pend_d = bus.vga_req;
      if (bus.vga_req) pend_addr_d = bus.vga_addr;
    end else if (grant_force && bus.vga_req) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_addr_d = bus.vga_addr;
      end
    end

    if (!bus.cpu_req || cpu_grant) begin
      wait_d = '0;
    end else if (cpu_can && (wait_q != MAX_WAIT_C)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Memory port registers, deferral slot and read-return tag pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      vga_rdata_q <= '0;
      vga_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      wait_q      <= wait_d;
      mem_we_q    <= 1'b0;
      if (vga_grant) begin
        mem_addr_q <= grant_pend ? pend_addr_q : bus.vga_addr;
      end else if (cpu_grant) begin
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
        mem_we_q    <= bus.cpu_we;
      end
      if (vga_grant)                    tag0_q <= TAG_VGA;
      else if (cpu_grant && !bus.cpu_we) tag0_q <= TAG_CPU;
      else                              tag0_q <= TAG_NONE;
      tag1_q      <= tag0_q;
      vga_valid_q <= (tag1_q == TAG_VGA);
      if (tag1_q == TAG_VGA) vga_rdata_q <= bus.mem_rdata;
      if (tag1_q == TAG_CPU) cpu_rdata_q <= bus.mem_rdata;
    end
  end

  // CPU transaction sequencing; cpu_ack pulses on the return to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cpu_ack_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (cpu_grant) state_q <= bus.cpu_we ? ST_WR : ST_RD1;
        ST_RD1:  state_q <= ST_RD2;
        ST_RD2: begin
          state_q   <= ST_IDLE;
          cpu_ack_q <= 1'b1;
        end
        ST_WR: begin
          state_q   <= ST_IDLE;
          cpu_ack_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.vga_rdata   = vga_rdata_q;
  assign bus.vga_valid   = vga_valid_q;
  assign bus.vga_overrun = overrun_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: block-RAM model, request scoreboard and
// directed plus randomized VGA/CPU traffic.
module tb_vga_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read block RAM, and the bench's own view of its contents.
  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request scoreboard: every VGA request the bench expects to be served.
  typedef struct packed {
    int unsigned   edge_no;
    logic [AW-1:0] addr;
  } vreq_t;

  vreq_t       vq[$];
  vreq_t       push_r, pop_r;
  int unsigned lat_q[$];
  int unsigned edge_n    = 0;
  logic        drop_next = 1'b0;
  int unsigned valid_cnt = 0, ack_cnt = 0, we_cycles = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!reset && bus.vga_req && !drop_next) begin
      push_r.edge_no = edge_n;
      push_r.addr    = bus.vga_addr;
      vq.push_back(push_r);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) we_cycles++;
      if (bus.cpu_ack) ack_cnt++;
      if (bus.vga_valid) begin
        valid_cnt++;
        check_eq("vga_valid_expected", 32'(vq.size() != 0), 1);
        if (vq.size() != 0) begin
          pop_r = vq.pop_front();
          check_eq("vga_data", 32'(bus.vga_rdata), 32'(shadow[pop_r.addr]));
          lat_q.push_back(edge_n - pop_r.edge_no);
        end
      end
    end
  end

  function automatic int unsigned pop_lat();
    if (lat_q.size() == 0) return 99;
    return lat_q.pop_front();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vga_burst(input int n, input int gap, input logic [AW-1:0] base, input int drop_idx);
    for (int i = 0; i < n; i++) begin
      bus.vga_req  = 1'b1;
      bus.vga_addr = base + AW'(i);
      drop_next    = (i == drop_idx);
      step();
      bus.vga_req = 1'b0;
      drop_next   = 1'b0;
      for (int g = 1; g < gap; g++) step();
    end
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int unsigned lat, output logic [DW-1:0] rd, output logic ok);
    int unsigned first;
    int unsigned n;
    first         = edge_n + 1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    if (we) shadow[addr] = wd;
    ok  = 1'b0;
    n   = 0;
    lat = 0;
    rd  = '0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack) begin
        ok  = 1'b1;
        lat = edge_n - first;
        rd  = bus.cpu_rdata;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  int unsigned   lat, lat2, v0, w0, a0, nwrites, l, nlat;
  logic [DW-1:0] rd, rd2, exp_rd, r_wd;
  logic          ok, ok2, r_we;
  logic [AW-1:0] r_addr;
  int unsigned   exp_starve [8]  = '{2, 2, 2, 2, 3, 3, 3, 3};
  int unsigned   exp_over   [15] = '{2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 4, 3, 3, 3};

  initial begin
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 16'(i) ^ 16'h5A5A;
      shadow[i] = 16'(i) ^ 16'h5A5A;
    end
    #2 reset = 1'b1;
    repeat (3) step();

    // Reset values
    check_eq("rst_mem_we", 32'(bus.mem_we), 0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check_eq("rst_vga_valid", 32'(bus.vga_valid), 0);
    check_eq("rst_vga_rdata", 32'(bus.vga_rdata), 0);
    check_eq("rst_cpu_ack", 32'(bus.cpu_ack), 0);
    check_eq("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check_eq("rst_overrun", 32'(bus.vga_overrun), 0);
    reset = 1'b0;
    step();

    // Reset in the middle of a VGA read: the fetch must vanish
    bus.vga_req  = 1'b1;
    bus.vga_addr = 16'hF123;
    step();
    bus.vga_req = 1'b0;
    step();
    reset = 1'b1;
    vq.delete();
    v0 = valid_cnt;
    step();
    check_eq("midrd_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("midrd_vga_valid", 32'(bus.vga_valid), 0);
    step();
    reset = 1'b0;
    repeat (6) step();
    check_eq("midrd_no_valid", valid_cnt - v0, 0);
    check_eq("midrd_vga_rdata", 32'(bus.vga_rdata), 0);
    check_eq("midrd_overrun", 32'(bus.vga_overrun), 0);

    // VGA-only stream, one request every two cycles
    lat_q.delete();
    v0 = valid_cnt;
    w0 = we_cycles;
    vga_burst(16, 2, 16'hF000, -1);
    repeat (5) step();
    check_eq("stream_count", valid_cnt - v0, 16);
    for (int i = 0; i < 16; i++) check_eq("stream_lat", pop_lat(), 2);
    check_eq("stream_no_we", we_cycles - w0, 0);

    // CPU write then read, no VGA traffic
    w0 = we_cycles;
    a0 = ack_cnt;
    cpu_op(1'b1, 16'h0040, 16'h1234, lat, rd, ok);
    check_eq("wr_ack_seen", 32'(ok), 1);
    check_eq("wr_ack_lat", lat, 1);
    step();
    check_eq("wr_we_cycles", we_cycles - w0, 1);
    cpu_op(1'b0, 16'h0040, 16'h0000, lat, rd, ok);
    check_eq("rd_ack_seen", 32'(ok), 1);
    check_eq("rd_ack_lat", lat, 2);
    check_eq("rd_data", 32'(rd), 32'h1234);
    repeat (4) step();
    check_eq("wrrd_ack_count", ack_cnt - a0, 2);

    // Starvation: VGA every cycle, CPU read held
    lat_q.delete();
    fork
      vga_burst(8, 1, 16'hF100, -1);
      cpu_op(1'b0, 16'h0040, 16'h0000, lat, rd, ok);
    join
    repeat (6) step();
    check_eq("starve_ack_seen", 32'(ok), 1);
    check_eq("starve_ack_lat", lat, 6);
    check_eq("starve_rd_data", 32'(rd), 32'h1234);
    check_eq("starve_nvalid", lat_q.size(), 8);
    for (int i = 0; i < 8; i++) check_eq("starve_vga_lat", pop_lat(), exp_starve[i]);
    check_eq("starve_overrun", 32'(bus.vga_overrun), 0);

    // Overrun: second forced CPU grant while the deferral slot is full
    lat_q.delete();
    fork
      vga_burst(16, 1, 16'hF200, 12);
      begin
        cpu_op(1'b0, 16'h0040, 16'h0000, lat, rd, ok);
        step();
        cpu_op(1'b1, 16'h0041, 16'hBEEF, lat2, rd2, ok2);
      end
    join
    repeat (6) step();
    check_eq("ovr_rd_seen", 32'(ok), 1);
    check_eq("ovr_rd_lat", lat, 6);
    check_eq("ovr_rd_data", 32'(rd), 32'h1234);
    check_eq("ovr_wr_seen", 32'(ok2), 1);
    check_eq("ovr_wr_lat", lat2, 5);
    check_eq("ovr_flag", 32'(bus.vga_overrun), 1);
    check_eq("ovr_nvalid", lat_q.size(), 15);
    for (int i = 0; i < 15; i++) check_eq("ovr_vga_lat", pop_lat(), exp_over[i]);
    repeat (10) step();
    check_eq("ovr_sticky", 32'(bus.vga_overrun), 1);
    reset = 1'b1;
    step();
    check_eq("ovr_rst_clear", 32'(bus.vga_overrun), 0);
    reset = 1'b0;
    step();
    check_eq("ovr_after_rst", 32'(bus.vga_overrun), 0);

    // Simultaneous VGA and CPU request with an empty wait counter
    lat_q.delete();
    a0 = ack_cnt;
    fork
      vga_burst(1, 1, 16'hF300, -1);
      cpu_op(1'b1, 16'h0042, 16'h5555, lat, rd, ok);
    join
    repeat (10) step();
    check_eq("sim_ack_seen", 32'(ok), 1);
    check_eq("sim_ack_lat", lat, 2);
    check_eq("sim_vga_lat", pop_lat(), 2);
    check_eq("sim_single_ack", ack_cnt - a0, 1);

    // Randomized mixed traffic within normal VGA pacing
    lat_q.delete();
    w0      = we_cycles;
    nwrites = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          vga_burst(1, 2 + int'($urandom_range(0, 3)), 16'hF000 + 16'($urandom_range(0, 4095)), -1);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          r_we   = 1'($urandom_range(0, 1));
          r_addr = 16'($urandom_range(0, 15));
          r_wd   = 16'($urandom);
          exp_rd = shadow[r_addr];
          cpu_op(r_we, r_addr, r_wd, lat, rd, ok);
          check_eq("rnd_cpu_ack_seen", 32'(ok), 1);
          check_eq("rnd_cpu_lat_bound", 32'(lat <= 6), 1);
          if (!r_we) check_eq("rnd_cpu_rdata", 32'(rd), 32'(exp_rd));
          else nwrites++;
          step();
          repeat ($urandom_range(0, 3)) step();
        end
      end
    join
    repeat (8) step();
    nlat = lat_q.size();
    check_eq("rnd_vga_count", nlat, 40);
    while (lat_q.size() != 0) begin
      l = pop_lat();
      check_eq("rnd_vga_lat", 32'((l == 2) || (l == 3)), 1);
    end
    check_eq("rnd_vga_outstanding", vq.size(), 0);
    check_eq("rnd_we_cycles", we_cycles - w0, nwrites);
    check_eq("rnd_overrun", 32'(bus.vga_overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
